// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end.
//   KEY_* : 5-bit key codes reported on eBCD (0..9 are the digits themselves)
//   deb_state_e : keypad debounce FSM states
//   key_sel_t / prio_enc : lowest-index pressed key out of an active-low keypad word
package calc_pkg;

  localparam logic [4:0] KEY_ADD  = 5'd10;
  localparam logic [4:0] KEY_SUB  = 5'd11;
  localparam logic [4:0] KEY_MUL  = 5'd12;
  localparam logic [4:0] KEY_DIV  = 5'd13;
  localparam logic [4:0] KEY_EQ   = 5'd14;
  localparam logic [4:0] KEY_CLR  = 5'd15;
  localparam logic [4:0] KEY_NONE = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } deb_state_e;

  typedef struct packed {
    logic       vld;  // at least one key pressed
    logic [3:0] idx;  // lowest pressed index
  } key_sel_t;

  // Walk from the top down so the lowest pressed index is the last writer.
  function automatic key_sel_t prio_enc(input logic [15:0] pb_n);
    key_sel_t s;
    s = '0;
    for (int i = 15; i >= 0; i--) begin
      if (!pb_n[i]) begin
        s.vld = 1'b1;
        s.idx = 4'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/clk_div_unit.sv
// Even-ratio clock divider used as an enable generator.
//   gclk    : system clock
//   grst_n  : async active-low reset
//   clk_out : 50% duty divided clock, period DIV, starts low
//   tick    : one-cycle pulse in the cycle clk_out has just gone high
module clk_div_unit #(
  parameter int DIV = 4
) (
  input  logic gclk,
  input  logic grst_n,
  output logic clk_out,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] HALF = W'(DIV / 2 - 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (cnt == HALF || cnt == LAST) clk_out <= ~clk_out;
      // clk_out is always low in the first half-period, so the HALF toggle is the rising one
      tick    <= (cnt == HALF);
    end
  end

endmodule

// File: rtl/keypad_frontend.sv
// Calculator front end: scan-rate dividers plus keypad debounce/encode.
//   clock_50m : system clock (only clock)
//   rst       : async active-low reset
//   pb[15:0]  : active-low pushbuttons
//   sw_clk    : switch-scan divided clock (period SW_DIV)
//   fnd_clk   : display-scan divided clock (period FND_DIV)
//   eBCD      : key code for one sw_clk period per new press, else KEY_NONE
//   key_rst   : high alongside eBCD when the clear key (15) fires
module keypad_frontend
  import calc_pkg::*;
#(
  parameter int SW_DIV  = 50000,
  parameter int FND_DIV = 5000,
  parameter int DEB_CNT = 2
) (
  input  logic        clock_50m,
  input  logic        rst,
  input  logic [15:0] pb,
  output logic        sw_clk,
  output logic        fnd_clk,
  output logic [4:0]  eBCD,
  output logic        key_rst
);

  localparam logic [3:0] DEB = 4'(DEB_CNT);

  logic       sw_tick;
  logic       fnd_tick_unused;
  logic [15:0] pb_s1, pb_s2;
  deb_state_e state;
  logic [3:0] cnt;
  logic [3:0] cand;
  logic [3:0] cnt_nxt;
  key_sel_t   sel;

  clk_div_unit #(.DIV(SW_DIV)) u_sw_div (
    .gclk(clock_50m), .grst_n(rst), .clk_out(sw_clk), .tick(sw_tick)
  );

  clk_div_unit #(.DIV(FND_DIV)) u_fnd_div (
    .gclk(clock_50m), .grst_n(rst), .clk_out(fnd_clk), .tick(fnd_tick_unused)
  );

  // Reset to all-released so nothing looks pressed while the synchroniser fills.
  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      pb_s1 <= '1;
      pb_s2 <= '1;
    end else begin
      pb_s1 <= pb;
      pb_s2 <= pb_s1;
    end
  end

  assign sel     = prio_enc(pb_s2);
  assign cnt_nxt = cnt + 4'd1;

  // cnt holds how many consecutive ticks the current candidate (key or idle) has been seen.
  // Events fire only on the released->pressed acceptance; a key change while HELD is ignored.
  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cand    <= '0;
      eBCD    <= KEY_NONE;
      key_rst <= 1'b0;
    end else if (sw_tick) begin
      eBCD    <= KEY_NONE;
      key_rst <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel.vld) begin
            cand <= sel.idx;
            if (DEB_CNT == 1) begin
              state   <= ST_HELD;
              eBCD    <= {1'b0, sel.idx};
              key_rst <= &sel.idx;
            end else begin
              cnt   <= 4'd1;
              state <= ST_PRESS_WAIT;
            end
          end
        end
        ST_PRESS_WAIT: begin
          if (!sel.vld) begin
            state <= ST_IDLE;
          end else if (sel.idx != cand) begin
            cand <= sel.idx;
            cnt  <= 4'd1;
          end else if (cnt_nxt >= DEB) begin
            state   <= ST_HELD;
            eBCD    <= {1'b0, cand};
            key_rst <= &cand;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        ST_HELD: begin
          if (!sel.vld) begin
            if (DEB_CNT == 1) begin
              state <= ST_IDLE;
            end else begin
              cnt   <= 4'd1;
              state <= ST_RELEASE_WAIT;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (sel.vld)              state <= ST_HELD;
          else if (cnt_nxt >= DEB)  state <= ST_IDLE;
          else                      cnt   <= cnt_nxt;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_frontend.sv
module tb_keypad_frontend;
  import calc_pkg::*;

  localparam int SWD = 10;
  localparam int FD  = 4;
  localparam int DEB = 2;

  logic        clock_50m = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pb = 16'hFFFF;
  logic        sw_clk, fnd_clk, key_rst;
  logic [4:0]  eBCD;

  keypad_frontend #(.SW_DIV(SWD), .FND_DIV(FD), .DEB_CNT(DEB)) dut (
    .clock_50m(clock_50m), .rst(rst), .pb(pb),
    .sw_clk(sw_clk), .fnd_clk(fnd_clk), .eBCD(eBCD), .key_rst(key_rst)
  );

  always #5 clock_50m = ~clock_50m;

  int checks = 0;
  int errors = 0;

  // Reference model: per scan tick, track how long the current candidate (lowest key, -1 = idle)
  // has persisted and whether a press is currently accepted.
  int         n;          // clock edges since reset release
  int         streak;
  int         prev_cand;
  bit         accepted;
  int         events;
  logic [4:0] exp_code;
  int         ev_cyc, zero_cyc, kr_cyc;

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (!v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; streak = 0; prev_cand = -1; accepted = 0; exp_code = KEY_NONE;
  endtask

  task automatic model_tick();
    int c;
    c = lowest(pb);
    streak    = (c == prev_cand) ? streak + 1 : 1;
    prev_cand = c;
    exp_code  = KEY_NONE;
    if (!accepted && c >= 0 && streak >= DEB) begin
      accepted = 1;
      exp_code = 5'(c);
      events++;
    end else if (accepted && c < 0 && streak >= DEB) begin
      accepted = 0;
    end
  endtask

  // One clock cycle: the DUT acts on the tick one edge after sw_clk rises (n%SWD == SWD/2+1),
  // looking at pb as it was two edges earlier. pb only changes at n%SWD == 8, well clear of that.
  task automatic step();
    @(posedge clock_50m);
    n++;
    if (n % SWD == SWD / 2 + 1) model_tick();
    #1;
    chk("sw_clk",  32'(sw_clk),  32'((n / (SWD / 2)) % 2));
    chk("fnd_clk", 32'(fnd_clk), 32'((n / (FD / 2)) % 2));
    chk("eBCD",    32'(eBCD),    32'(exp_code));
    chk("key_rst", 32'(key_rst), 32'(exp_code == 5'h0F));
    if (eBCD !== KEY_NONE) ev_cyc++;
    if (eBCD === 5'h00) zero_cyc++;
    if (key_rst === 1'b1) kr_cyc++;
  endtask

  task automatic hold(input logic [15:0] v, input int ticks);
    pb = v;
    repeat (ticks * SWD) step();
  endtask

  task automatic clr_counts();
    ev_cyc = 0; zero_cyc = 0; kr_cyc = 0; events = 0;
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_sw"},  32'(sw_clk),  32'd0);
    chk({tag, "_fnd"}, 32'(fnd_clk), 32'd0);
    chk({tag, "_bcd"}, 32'(eBCD),    32'(KEY_NONE));
    chk({tag, "_kr"},  32'(key_rst), 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    int          r, d;
    model_reset();
    clr_counts();

    // Reset held 5 cycles
    repeat (5) begin
      @(posedge clock_50m); #1;
      check_in_reset("rst_hold");
    end
    rst = 1'b1;
    model_reset();
    repeat (8) step();
    hold(16'hFFFF, 2);

    // Single press of key 0 for 50 cycles
    clr_counts();
    hold(16'hFFFE, 5);
    hold(16'hFFFF, 3);
    chk("key0_cycles", 32'(zero_cyc), 32'd10);
    chk("key0_events", 32'(ev_cyc), 32'd10);

    // Walk every key
    clr_counts();
    for (int i = 0; i < 16; i++) begin
      v = ~(16'h0001 << i);
      hold(v, 5);
      hold(16'hFFFF, 3);
    end
    chk("walk_event_cycles", 32'(ev_cyc), 32'd160);
    chk("walk_keyrst_cycles", 32'(kr_cyc), 32'd10);
    chk("walk_model_events", 32'(events), 32'd16);

    // One-tick glitch on key 3
    clr_counts();
    hold(16'hFFF7, 1);
    hold(16'hFFFF, 3);
    chk("glitch_events", 32'(ev_cyc), 32'd0);

    // Keys 1 and 2 together, held long: one event for key 1 only
    clr_counts();
    hold(16'hFFF9, 100);
    hold(16'hFFFF, 3);
    chk("hold_event_cycles", 32'(ev_cyc), 32'd10);
    chk("hold_model_events", 32'(events), 32'd1);

    // Direct switch between keys without idle: only the first press reports
    clr_counts();
    hold(16'hFFBF, 4);
    hold(16'hFF7F, 4);
    hold(16'hFFFF, 3);
    chk("switch_event_cycles", 32'(ev_cyc), 32'd10);

    // Async reset while eBCD shows key 5; key stays held across release
    hold(16'hFFDF, 2);
    chk("pre_rst_bcd", 32'(eBCD), 32'h05);
    #2 rst = 1'b0;
    #1 check_in_reset("async_rst");
    repeat (3) begin
      @(posedge clock_50m); #1;
      check_in_reset("mid_rst_hold");
    end
    rst = 1'b1;
    model_reset();
    clr_counts();
    repeat (8) step();
    hold(16'hFFDF, 4);
    hold(16'hFFFF, 3);
    chk("post_rst_event_cycles", 32'(ev_cyc), 32'd10);
    chk("post_rst_model_events", 32'(events), 32'd1);

    // Random patterns checked cycle by cycle against the model
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 3));
      d = int'($urandom_range(1, 4));
      case (r)
        0: v = 16'hFFFF;
        1: v = ~(16'h0001 << $urandom_range(0, 15));
        2: v = ~((16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15)));
        default: v = 16'($urandom);
      endcase
      hold(v, d);
    end
    hold(16'hFFFF, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
